// File: rtl/mem_axi_bridge.sv
// Single-outstanding AXI4 master behind the MEM stage. It turns level-held read/write
// requests into single-beat bursts and answers each one with a one-cycle Finish pulse.
module mem_axi_bridge #(
    parameter int          ADDR_W = 64,
    parameter int          DATA_W = 64,
    parameter logic [2:0]  AXSIZE = 3'b011,
    localparam int         STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              Read_Start,
    input  logic [ADDR_W-1:0] Read_ADDR,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Finish_Read,

    input  logic              Write_Start,
    input  logic [ADDR_W-1:0] Write_ADDR,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic [STRB_W-1:0] Write_Strb,
    output logic              Finish_Write,

    output logic              Resp_Err,

    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,

    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,

    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    output logic              wlast,
    input  logic              wready,

    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_REL     = 3'd5
    } state_t;

    state_t              r_state, w_state_next;

    logic                r_arvalid,   w_arvalid_next;
    logic [ADDR_W-1:0]   r_araddr,    w_araddr_next;
    logic                r_rready,    w_rready_next;
    logic [DATA_W-1:0]   r_read_data, w_read_data_next;
    logic                r_finish_rd, w_finish_rd_next;
    logic                r_awvalid,   w_awvalid_next;
    logic [ADDR_W-1:0]   r_awaddr,    w_awaddr_next;
    logic                r_wvalid,    w_wvalid_next;
    logic [DATA_W-1:0]   r_wdata,     w_wdata_next;
    logic [STRB_W-1:0]   r_wstrb,     w_wstrb_next;
    logic                r_aw_done,   w_aw_done_next;
    logic                r_w_done,    w_w_done_next;
    logic                r_bready,    w_bready_next;
    logic                r_finish_wr, w_finish_wr_next;
    logic                r_resp_err,  w_resp_err_next;
    logic                r_rel_rd,    w_rel_rd_next;

    logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic w_aw_fin, w_w_fin;
    logic w_unused_rlast;

    assign w_ar_hs  = r_arvalid & arready;
    assign w_r_hs   = r_rready  & rvalid;
    assign w_aw_hs  = r_awvalid & awready;
    assign w_w_hs   = r_wvalid  & wready;
    assign w_b_hs   = r_bready  & bvalid;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done  | w_w_hs;

    // Single-beat bursts only, so rlast carries no information.
    assign w_unused_rlast = rlast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_rready    <= 1'b0;
            r_read_data <= '0;
            r_finish_rd <= 1'b0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_finish_wr <= 1'b0;
            r_resp_err  <= 1'b0;
            r_rel_rd    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_arvalid   <= w_arvalid_next;
            r_araddr    <= w_araddr_next;
            r_rready    <= w_rready_next;
            r_read_data <= w_read_data_next;
            r_finish_rd <= w_finish_rd_next;
            r_awvalid   <= w_awvalid_next;
            r_awaddr    <= w_awaddr_next;
            r_wvalid    <= w_wvalid_next;
            r_wdata     <= w_wdata_next;
            r_wstrb     <= w_wstrb_next;
            r_aw_done   <= w_aw_done_next;
            r_w_done    <= w_w_done_next;
            r_bready    <= w_bready_next;
            r_finish_wr <= w_finish_wr_next;
            r_resp_err  <= w_resp_err_next;
            r_rel_rd    <= w_rel_rd_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Read_Start)       w_state_next = S_RD_ADDR;
                else if (Write_Start) w_state_next = S_WR_REQ;
            end
            S_RD_ADDR: if (w_ar_hs)              w_state_next = S_RD_DATA;
            S_RD_DATA: if (w_r_hs)               w_state_next = S_REL;
            S_WR_REQ:  if (w_aw_fin && w_w_fin)  w_state_next = S_WR_RESP;
            S_WR_RESP: if (w_b_hs)               w_state_next = S_REL;
            // Wait for MEM to drop the request it just got a Finish for.
            S_REL: begin
                if (r_rel_rd ? !Read_Start : !Write_Start) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_arvalid_next   = r_arvalid;
        w_araddr_next    = r_araddr;
        w_rready_next    = r_rready;
        w_read_data_next = r_read_data;
        w_finish_rd_next = 1'b0;
        w_awvalid_next   = r_awvalid;
        w_awaddr_next    = r_awaddr;
        w_wvalid_next    = r_wvalid;
        w_wdata_next     = r_wdata;
        w_wstrb_next     = r_wstrb;
        w_aw_done_next   = r_aw_done;
        w_w_done_next    = r_w_done;
        w_bready_next    = r_bready;
        w_finish_wr_next = 1'b0;
        w_resp_err_next  = r_resp_err;
        w_rel_rd_next    = r_rel_rd;
        case (r_state)
            S_IDLE: begin
                if (Read_Start) begin
                    w_araddr_next  = Read_ADDR;
                    w_arvalid_next = 1'b1;
                end else if (Write_Start) begin
                    w_awaddr_next  = Write_ADDR;
                    w_wdata_next   = Write_Data;
                    w_wstrb_next   = Write_Strb;
                    w_awvalid_next = 1'b1;
                    w_wvalid_next  = 1'b1;
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_arvalid_next = 1'b0;
                    w_rready_next  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (w_r_hs) begin
                    w_rready_next    = 1'b0;
                    w_read_data_next = rdata;
                    w_finish_rd_next = 1'b1;
                    w_resp_err_next  = r_resp_err | (rresp != 2'b00);
                    w_rel_rd_next    = 1'b1;
                end
            end
            S_WR_REQ: begin
                if (w_aw_hs) begin
                    w_awvalid_next = 1'b0;
                    w_aw_done_next = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_next = 1'b0;
                    w_w_done_next = 1'b1;
                end
                if (w_aw_fin && w_w_fin) w_bready_next = 1'b1;
            end
            S_WR_RESP: begin
                if (w_b_hs) begin
                    w_bready_next    = 1'b0;
                    w_finish_wr_next = 1'b1;
                    w_resp_err_next  = r_resp_err | (bresp != 2'b00);
                    w_rel_rd_next    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign Read_Data    = r_read_data;
    assign Finish_Read  = r_finish_rd;
    assign Finish_Write = r_finish_wr;
    assign Resp_Err     = r_resp_err;
    assign araddr       = r_araddr;
    assign arvalid      = r_arvalid;
    assign rready       = r_rready;
    assign awaddr       = r_awaddr;
    assign awvalid      = r_awvalid;
    assign wdata        = r_wdata;
    assign wstrb        = r_wstrb;
    assign wvalid       = r_wvalid;
    assign bready       = r_bready;

    assign arlen   = 8'd0;
    assign arsize  = AXSIZE;
    assign arburst = 2'b01;
    assign awlen   = 8'd0;
    assign awsize  = AXSIZE;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: the bench plays MEM and the AXI slave cycle by cycle,
// with queued expected read data / write beats checked as the bridge produces them.
module tb_mem_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        Read_Start, Write_Start;
    logic [63:0] Read_ADDR, Write_ADDR, Write_Data;
    logic [7:0]  Write_Strb;
    logic [63:0] Read_Data;
    logic        Finish_Read, Finish_Write, Resp_Err;
    logic [63:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } wr_t;

    logic [63:0] rd_q[$];
    wr_t         wr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fr_cnt = 0;
    int          fw_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Finish_Read)  fr_cnt++;
        if (Finish_Write) fw_cnt++;
    end

    mem_axi_bridge dut (
        .clk(clk), .rst(rst),
        .Read_Start(Read_Start), .Read_ADDR(Read_ADDR), .Read_Data(Read_Data),
        .Finish_Read(Finish_Read),
        .Write_Start(Write_Start), .Write_ADDR(Write_ADDR), .Write_Data(Write_Data),
        .Write_Strb(Write_Strb), .Finish_Write(Finish_Write), .Resp_Err(Resp_Err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"},  wvalid, 0);
        chk({tag, "_rready"},  rready, 0);
        chk({tag, "_bready"},  bready, 0);
        chk({tag, "_fin_rd"},  Finish_Read, 0);
        chk({tag, "_fin_wr"},  Finish_Write, 0);
        chk({tag, "_resp_err"}, Resp_Err, 0);
        chk({tag, "_read_data"}, Read_Data, 0);
        chk({tag, "_araddr"},  araddr, 0);
        chk({tag, "_awaddr"},  awaddr, 0);
        chk({tag, "_wdata"},   wdata, 0);
        chk({tag, "_wstrb"},   wstrb, 0);
    endtask

    // Read issued at the first edge; slave waits ar_wait cycles on AR and r_wait on R.
    task automatic do_read(input logic [63:0] addr, input logic [63:0] data,
                           input logic [1:0] resp, input int ar_wait, input int r_wait,
                           input int rel_hold);
        logic [63:0] e;
        rd_q.push_back(data);
        Read_ADDR  = addr;
        Read_Start = 1'b1;
        tick;
        chk("arvalid_issue", arvalid, 1);
        chk("araddr", araddr, addr);
        repeat (ar_wait) begin
            tick;
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, addr);
            chk("rready_early", rready, 0);
        end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 0);
        chk("rready_set", rready, 1);
        repeat (r_wait) begin
            tick;
            chk("rready_hold", rready, 1);
            chk("fin_rd_early", Finish_Read, 0);
        end
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        tick;
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
        e = rd_q.pop_front();
        chk("fin_rd", Finish_Read, 1);
        chk("read_data", Read_Data, e);
        chk("rready_drop", rready, 0);
        repeat (rel_hold) begin
            tick;
            chk("fin_rd_pulse", Finish_Read, 0);
            chk("rel_no_reissue", arvalid, 0);
            chk("rel_no_write", awvalid, 0);
            chk("read_data_hold", Read_Data, e);
        end
        Read_Start = 1'b0;
        tick;
        chk("idle_arvalid", arvalid, 0);
        chk("idle_awvalid", awvalid, 0);
    endtask

    // Write issued at the first edge; W accepted at edge w_at, AW at edge aw_at after issue.
    task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic [1:0] resp,
                            input int w_at, input int aw_at, input int b_wait,
                            input int rel_hold);
        int last;
        last = (w_at > aw_at) ? w_at : aw_at;
        wr_q.push_back('{a: addr, d: data, s: strb});
        Write_ADDR  = addr;
        Write_Data  = data;
        Write_Strb  = strb;
        Write_Start = 1'b1;
        tick;
        chk("awvalid_issue", awvalid, 1);
        chk("wvalid_issue", wvalid, 1);
        chk("bready_early", bready, 0);
        for (int c = 1; c <= last; c++) begin
            wready  = (c == w_at);
            awready = (c == aw_at);
            if (wready && wvalid) begin
                chk("wdata", wdata, wr_q[0].d);
                chk("wstrb", wstrb, wr_q[0].s);
            end
            if (awready && awvalid) chk("awaddr", awaddr, wr_q[0].a);
            tick;
            wready  = 1'b0;
            awready = 1'b0;
            chk("wvalid_step", wvalid, (c < w_at));
            chk("awvalid_step", awvalid, (c < aw_at));
            chk("bready_step", bready, (c == last));
        end
        repeat (b_wait) begin
            tick;
            chk("bready_hold", bready, 1);
            chk("fin_wr_early", Finish_Write, 0);
        end
        bvalid = 1'b1;
        bresp  = resp;
        tick;
        bvalid = 1'b0;
        bresp  = 2'b00;
        void'(wr_q.pop_front());
        chk("fin_wr", Finish_Write, 1);
        chk("bready_drop", bready, 0);
        repeat (rel_hold) begin
            tick;
            chk("fin_wr_pulse", Finish_Write, 0);
            chk("rel_no_reissue_w", awvalid, 0);
            chk("rel_no_reissue_wv", wvalid, 0);
        end
        Write_Start = 1'b0;
        tick;
        chk("idle_awvalid_w", awvalid, 0);
    endtask

    initial begin
        int fr0, fw0;
        rst = 1'b0;
        Read_Start = 0; Write_Start = 0;
        Read_ADDR = '0; Write_ADDR = '0; Write_Data = '0; Write_Strb = '0;
        arready = 0; awready = 0; wready = 0;
        rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 1'b1;
        bvalid = 0; bresp = 2'b00;
        #3;
        chk_all_zero("reset");
        chk("arlen", arlen, 0);
        chk("awlen", awlen, 0);
        chk("arsize", arsize, 3'b011);
        chk("awsize", awsize, 3'b011);
        chk("arburst", arburst, 2'b01);
        chk("awburst", awburst, 2'b01);
        chk("wlast", wlast, 1);
        tick;
        tick;
        rst = 1'b1;
        tick;

        // zero-wait read, MEM holds the request one cycle past Finish
        do_read(64'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 1);
        chk("resp_err_ok_rd", Resp_Err, 0);
        tick;

        // back-pressured read
        do_read(64'h8000_0048, 64'hCAFE_F00D_0BAD_BEEF, 2'b00, 4, 2, 0);
        tick;

        // W before AW
        do_write(64'h8000_0100, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2'b00, 1, 3, 0, 1);
        chk("resp_err_ok_wr", Resp_Err, 0);
        tick;

        // AW and W in the same cycle, B delayed
        do_write(64'h8000_0200, 64'h0123_4567_89AB_CDEF, 8'hF0, 2'b00, 2, 2, 1, 0);
        tick;

        // AW before W
        do_write(64'h8000_0300, 64'hA5A5_5A5A_A5A5_5A5A, 8'hFF, 2'b00, 3, 1, 0, 0);
        tick;

        // simultaneous requests: read first, write only after Read_Start drops
        fr0 = fr_cnt;
        fw0 = fw_cnt;
        Write_ADDR  = 64'h8000_0400;
        Write_Data  = 64'h1111_2222_3333_4444;
        Write_Strb  = 8'hFF;
        Write_Start = 1'b1;
        do_read(64'h8000_0408, 64'h5555_6666_7777_8888, 2'b00, 1, 0, 2);
        do_write(64'h8000_0400, 64'h1111_2222_3333_4444, 8'hFF, 2'b00, 1, 1, 0, 1);
        tick;
        chk("simul_fin_rd_once", fr_cnt - fr0, 1);
        chk("simul_fin_wr_once", fw_cnt - fw0, 1);

        // error response is sticky through a later OKAY read
        do_write(64'h8000_0500, 64'h0, 8'h01, 2'b10, 1, 1, 0, 0);
        chk("resp_err_set", Resp_Err, 1);
        tick;
        do_read(64'h8000_0508, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00, 0, 1, 0);
        chk("resp_err_sticky", Resp_Err, 1);
        tick;

        // async reset while waiting in RD_DATA
        fr0 = fr_cnt;
        Read_ADDR  = 64'h8000_0600;
        Read_Start = 1'b1;
        tick;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        chk("rst_pre_rready", rready, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        Read_Start = 1'b0;
        tick;
        chk("async_rst_no_fin", Finish_Read, 0);
        rst = 1'b1;
        tick;
        chk("async_rst_fin_count", fr_cnt - fr0, 0);
        do_read(64'h8000_0700, 64'h7777_0000_7777_0000, 2'b00, 0, 0, 0);
        chk("resp_err_after_rst", Resp_Err, 0);

        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
